// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: groups the fetch port, the data port and the shared
// memory bus of mem_port_arbiter into one bundle.
// master : arbiter view (serves both requesters, drives the memory bus)
// slave  : environment view (requesters plus bus device)
interface mem_port_arbiter_if #(
    parameter int XLEN = 64
);
    // instruction fetch port
    logic            if_req;
    logic [XLEN-1:0] if_addr;
    logic [XLEN-1:0] if_rdata;
    logic            if_ready;
    logic            if_error;
    // data (memacc) port
    logic            d_read_req;
    logic            d_write_req;
    logic [XLEN-1:0] d_addr;
    logic [XLEN-1:0] d_wdata;
    logic [2:0]      d_size;
    logic [XLEN-1:0] d_rdata;
    logic            d_ready;
    logic            d_error;
    // shared core memory bus
    logic            bus_req;
    logic            bus_we;
    logic [XLEN-1:0] bus_addr;
    logic [XLEN-1:0] bus_wdata;
    logic [2:0]      bus_size;
    logic [XLEN-1:0] bus_rdata;
    logic            bus_ack;
    logic            bus_err;

    modport master (
        input  if_req, if_addr,
        output if_rdata, if_ready, if_error,
        input  d_read_req, d_write_req, d_addr, d_wdata, d_size,
        output d_rdata, d_ready, d_error,
        output bus_req, bus_we, bus_addr, bus_wdata, bus_size,
        input  bus_rdata, bus_ack, bus_err
    );

    modport slave (
        output if_req, if_addr,
        input  if_rdata, if_ready, if_error,
        output d_read_req, d_write_req, d_addr, d_wdata, d_size,
        input  d_rdata, d_ready, d_error,
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_size,
        output bus_rdata, bus_ack, bus_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single core memory bus between instruction
// fetch and the memacc data port, one transaction at a time.
// IDLE grants a port, BUSY waits for ack/err/timeout, DONE issues a one-cycle
// ready pulse with registered rdata/error to the winner. All outputs registered.
// Optional build macro MEM_ARB_RR_EN: round-robin arbitration (the port not
// granted last wins a tie). Without it the data port always beats fetch.
module mem_port_arbiter #(
    parameter int XLEN           = 64,
    parameter int TIMEOUT_CYCLES = 255   // 0 disables the bus timeout
) (
    input  logic                clk,
    input  logic                resetn,
    mem_port_arbiter_if.master  port
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam bit         TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0]      state_reg;
    logic [7:0]      wait_cnt_reg;
    logic            winner_d_reg;      // 1 = data port owns the transaction
    logic            bus_req_reg;
    logic            bus_we_reg;
    logic [XLEN-1:0] bus_addr_reg;
    logic [XLEN-1:0] bus_wdata_reg;
    logic [2:0]      bus_size_reg;
    logic [XLEN-1:0] if_rdata_reg;
    logic            if_ready_reg;
    logic            if_error_reg;
    logic [XLEN-1:0] d_rdata_reg;
    logic            d_ready_reg;
    logic            d_error_reg;
`ifdef MEM_ARB_RR_EN
    logic            last_d_reg;        // 1 = data port was granted last
`endif

    logic            d_req;
    logic            grant_d;
    logic            grant_i;
    logic [XLEN-1:0] align_mask;
    logic            d_misaligned;

    // A load and a store raised together are served as a store.
    assign d_req        = port.d_read_req | port.d_write_req;
    assign align_mask   = (XLEN'(1) << port.d_size) - XLEN'(1);
    assign d_misaligned = |(port.d_addr & align_mask);

`ifdef MEM_ARB_RR_EN
    assign grant_d = d_req & (~port.if_req | ~last_d_reg);
`else
    assign grant_d = d_req;
`endif
    assign grant_i = port.if_req & ~grant_d;

    // Transaction FSM: grant in IDLE, bus wait in BUSY, ready pulse retires in DONE.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg     <= ST_IDLE;
            wait_cnt_reg  <= '0;
            winner_d_reg  <= 1'b0;
            bus_req_reg   <= 1'b0;
            bus_we_reg    <= 1'b0;
            bus_addr_reg  <= '0;
            bus_wdata_reg <= '0;
            bus_size_reg  <= '0;
            if_rdata_reg  <= '0;
            if_ready_reg  <= 1'b0;
            if_error_reg  <= 1'b0;
            d_rdata_reg   <= '0;
            d_ready_reg   <= 1'b0;
            d_error_reg   <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_d_reg    <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (grant_d) begin
                        winner_d_reg  <= 1'b1;
                        bus_we_reg    <= port.d_write_req;
                        bus_addr_reg  <= port.d_addr;
                        bus_wdata_reg <= port.d_wdata;
                        bus_size_reg  <= port.d_size;
`ifdef MEM_ARB_RR_EN
                        last_d_reg    <= 1'b1;
`endif
                        if (d_misaligned) begin
                            // Rejected locally: the bus never sees it.
                            d_ready_reg <= 1'b1;
                            d_error_reg <= 1'b1;
                            d_rdata_reg <= '0;
                            state_reg   <= ST_DONE;
                        end else begin
                            bus_req_reg  <= 1'b1;
                            wait_cnt_reg <= '0;
                            state_reg    <= ST_BUSY;
                        end
                    end else if (grant_i) begin
                        winner_d_reg  <= 1'b0;
                        bus_we_reg    <= 1'b0;
                        bus_addr_reg  <= port.if_addr;
                        bus_wdata_reg <= '0;
                        bus_size_reg  <= 3'd2;
`ifdef MEM_ARB_RR_EN
                        last_d_reg    <= 1'b0;
`endif
                        bus_req_reg   <= 1'b1;
                        wait_cnt_reg  <= '0;
                        state_reg     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (bus_req_reg && (port.bus_ack || port.bus_err)) begin
                        // bus_err wins over a simultaneous bus_ack.
                        bus_req_reg <= 1'b0;
                        state_reg   <= ST_DONE;
                        if (winner_d_reg) begin
                            d_ready_reg <= 1'b1;
                            d_error_reg <= port.bus_err;
                            d_rdata_reg <= port.bus_err ? '0 : port.bus_rdata;
                        end else begin
                            if_ready_reg <= 1'b1;
                            if_error_reg <= port.bus_err;
                            if_rdata_reg <= port.bus_err ? '0 : port.bus_rdata;
                        end
                    end else if (TIMEOUT_EN && (wait_cnt_reg == TIMEOUT_LAST)) begin
                        // Give up on the bus; a later ack is never sampled.
                        bus_req_reg <= 1'b0;
                        state_reg   <= ST_DONE;
                        if (winner_d_reg) begin
                            d_ready_reg <= 1'b1;
                            d_error_reg <= 1'b1;
                            d_rdata_reg <= '0;
                        end else begin
                            if_ready_reg <= 1'b1;
                            if_error_reg <= 1'b1;
                            if_rdata_reg <= '0;
                        end
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 8'd1;
                    end
                end
                ST_DONE: begin
                    // Ready lasts one cycle; rdata holds, error clears with it.
                    if_ready_reg <= 1'b0;
                    if_error_reg <= 1'b0;
                    d_ready_reg  <= 1'b0;
                    d_error_reg  <= 1'b0;
                    state_reg    <= ST_IDLE;
                end
                default: begin
                    bus_req_reg <= 1'b0;
                    state_reg   <= ST_IDLE;
                end
            endcase
        end
    end

    assign port.bus_req   = bus_req_reg;
    assign port.bus_we    = bus_we_reg;
    assign port.bus_addr  = bus_addr_reg;
    assign port.bus_wdata = bus_wdata_reg;
    assign port.bus_size  = bus_size_reg;
    assign port.if_rdata  = if_rdata_reg;
    assign port.if_ready  = if_ready_reg;
    assign port.if_error  = if_error_reg;
    assign port.d_rdata   = d_rdata_reg;
    assign port.d_ready   = d_ready_reg;
    assign port.d_error   = d_error_reg;
endmodule
